tap_ctrl_param: RTL
===================

# tap_ctrl_param

Parametrised IEEE 1149.1-style TAP controller. It succeeds the fixed 4-output TAP router with the full 16-state FSM and state observation. It adds an instruction register of configurable width, a bypass register, an IDCODE register, and one user data register with capture/update ports. It sits at the chip test boundary, clocked by the global test clock, and drives internal user-register logic plus a serial TDO pad.

## Interface
Parameters:
- IR_W, 4, instruction register width (≥2)
- DR_W, 8, user data register width (≥1)
- IDCODE_VAL, 32'h0000_0001, value captured by IDCODE (bit 0 must be 1)
- IDCODE_OP, 4'b0001, IR code selecting IDCODE (IR_W bits)
- USER_OP, 4'b0010, IR code selecting the user DR (IR_W bits)

Ports:
- GCLK_Pad  in  1  test clock, all state changes on rising edge
- TRST_N_Pad  in  1  asynchronous active-low reset
- TMS_Pad  in  1  mode select, sampled on rising edge
- TDI_Pad  in  1  serial data in
- TDO_Pad  out  1  serial data out
- tdo_en_Pad  out  1  high in Shift-IR/Shift-DR
- state_obs_Pad  out  4  current FSM state code
- ir_Pad  out  IR_W  current (updated) instruction
- user_dr_in  in  DR_W  parallel value captured into user DR
- user_dr_out  out  DR_W  updated user DR value
- user_upd  out  1  one-cycle pulse when user_dr_out is written

## Operation
- The FSM has 16 states using standard 1149.1 encodings:
  - TLR=F, RTI=C, SelDR=7, CapDR=6, ShDR=2, Ex1DR=1, PsDR=3, Ex2DR=0, UpdDR=5
  - SelIR=4, CapIR=E, ShIR=A, Ex1IR=9, PsIR=B, Ex2IR=8, UpdIR=D
- Transitions follow the standard TMS graph. Five consecutive TMS=1 edges reach TLR from any state.
- DR selection by ir_Pad:
  - IDCODE_OP selects the 32-bit IDCODE register.
  - USER_OP selects the DR_W user register.
  - All other codes, including all-ones, select the 1-bit bypass.
- Capture (edge while in CapxR) loads the shift register:
  - IR: {0…0,01}
  - IDCODE: IDCODE_VAL
  - user: user_dr_in
  - bypass: 0
- Shift (edge while in ShxR) shifts right: TDI enters the MSB of the selected register, and TDO_Pad = its LSB (combinational).
- Outside Shift states, TDO_Pad=0 and tdo_en_Pad=0.
- Update (edge while in UpdIR): ir_Pad ← IR shift register.
- Update (edge while in UpdDR with USER_OP selected): user_dr_out ← user shift register, and user_upd=1 for that following cycle.
- In TLR, each edge forces ir_Pad ← IDCODE_OP.
- Pause/Exit states hold all shift registers.

## Timing
- Reset (TRST_N_Pad low, asynchronous) sets:
  - state TLR (state_obs_Pad=4'hF)
  - ir_Pad=IDCODE_OP
  - all shift registers 0
  - user_dr_out=0, user_upd=0
  - TDO_Pad=0, tdo_en_Pad=0
- Reset deassertion takes effect on the next rising edge. Release must meet recovery time relative to GCLK_Pad.
- state_obs_Pad changes one edge after TMS is sampled, with zero extra latency.
- First TDO bit = LSB of the captured value, valid in the first ShxR cycle.
- An N-bit register needs N ShxR edges. The last bit is shifted on the edge that exits to Ex1xR (TMS=1).
- ir_Pad and user_dr_out change on the edge leaving UpdxR, and are visible in the next state (RTI or SelDR).
- Reset asserted mid-shift aborts the scan. The partial data is discarded, and ir_Pad and user_dr_out revert to reset values.
- A TMS change on the same edge as capture or update is handled as follows: the action belongs to the state being left; the new state comes from TMS.

## Structure
- Shared package tap_pkg:
  - state enum with the 16 encodings above
  - BYPASS constant (all ones)
  - IR capture constant 2'b01
- Sub-module tap_fsm: TMS-driven 16-state next-state logic plus state register, exporting state and decoded capture/shift/update strobes.
- The top level contains the IR, DR mux, shift registers and TDO mux.

## Test plan
- Reset, then hold TMS=0 for 1 edge: state_obs goes F→C; ir_Pad=0001; TDO_Pad=0.
- From ShDR, five TMS=1 edges: state_obs goes 2→1→5→7→4→F; ir_Pad=0001.
- IR scan shifting TDI=0,1,0,0: TDO outputs 1,0,0,0 (capture 01). After UpdIR, ir_Pad=0010.
- IDCODE readout after reset: 32 ShDR edges give IDCODE_VAL LSB-first, starting with 1.
- USER_OP with user_dr_in=8'hA5, shifting in 8'h3C: TDO gives A5 LSB-first. After UpdDR, user_dr_out=8'h3C and user_upd pulses for exactly one cycle.
- IR=1111 (bypass): TDI pattern 1,0,1,1 appears on TDO one edge later, preceded by 0. Asserting TRST_N_Pad low mid-shift gives state_obs=F immediately and user_dr_out=0.

Source files
------------

// File: rtl/tap_pkg.sv
// Shared TAP definitions: state encodings, data-register select codes and the
// standard TMS transition graph.
package tap_pkg;

  typedef enum logic [3:0] {
    EX2DR = 4'h0,
    EX1DR = 4'h1,
    SHDR  = 4'h2,
    PSDR  = 4'h3,
    SELIR = 4'h4,
    UPDDR = 4'h5,
    CAPDR = 4'h6,
    SELDR = 4'h7,
    EX2IR = 4'h8,
    EX1IR = 4'h9,
    SHIR  = 4'hA,
    PSIR  = 4'hB,
    RTI   = 4'hC,
    UPDIR = 4'hD,
    CAPIR = 4'hE,
    TLR   = 4'hF
  } tap_state_e;

  typedef enum logic [1:0] {
    SEL_BYPASS = 2'd0,
    SEL_IDCODE = 2'd1,
    SEL_USER   = 2'd2
  } dr_sel_e;

  // Wide enough for any IR_W; slice to the instruction width where used.
  localparam logic [31:0] BYPASS     = 32'hFFFF_FFFF;
  localparam logic [1:0]  IR_CAPTURE = 2'b01;

  function automatic tap_state_e tap_next(input tap_state_e s, input logic tms);
    tap_state_e n;
    case (s)
      TLR:     n = tms ? TLR   : RTI;
      RTI:     n = tms ? SELDR : RTI;
      SELDR:   n = tms ? SELIR : CAPDR;
      CAPDR:   n = tms ? EX1DR : SHDR;
      SHDR:    n = tms ? EX1DR : SHDR;
      EX1DR:   n = tms ? UPDDR : PSDR;
      PSDR:    n = tms ? EX2DR : PSDR;
      EX2DR:   n = tms ? UPDDR : SHDR;
      UPDDR:   n = tms ? SELDR : RTI;
      SELIR:   n = tms ? TLR   : CAPIR;
      CAPIR:   n = tms ? EX1IR : SHIR;
      SHIR:    n = tms ? EX1IR : SHIR;
      EX1IR:   n = tms ? UPDIR : PSIR;
      PSIR:    n = tms ? EX2IR : PSIR;
      EX2IR:   n = tms ? UPDIR : SHIR;
      UPDIR:   n = tms ? SELDR : RTI;
      default: n = TLR;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/tap_ctrl_param_if.sv
// Bundle between the TAP state machine and the register datapath: TMS in,
// current state plus the action strobes decoded from it out.
interface tap_ctrl_param_if;
  import tap_pkg::*;

  // Each strobe is high for the whole cycle the FSM sits in the matching
  // state; the datapath acts on the rising edge that leaves that state.
  // There is no back-pressure, so no ready/valid pairing is involved.
  logic       tms;
  tap_state_e state;
  logic       test_logic_reset;
  logic       capture_dr;
  logic       shift_dr;
  logic       update_dr;
  logic       capture_ir;
  logic       shift_ir;
  logic       update_ir;

  modport master (
    input  tms,
    output state, test_logic_reset, capture_dr, shift_dr, update_dr,
           capture_ir, shift_ir, update_ir
  );

  modport slave (
    output tms,
    input  state, test_logic_reset, capture_dr, shift_dr, update_dr,
           capture_ir, shift_ir, update_ir
  );

endinterface

// File: rtl/tap_fsm.sv
// 16-state TMS-driven TAP state machine; exports the state register and the
// capture/shift/update strobes decoded from it.
module tap_fsm
  import tap_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  tap_ctrl_param_if.master bus
);

  tap_state_e state_q;
  tap_state_e state_d;

  always_comb begin
    state_d = tap_next(state_q, bus.tms);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= TLR;
    end else begin
      state_q <= state_d;
    end
  end

  assign bus.state            = state_q;
  assign bus.test_logic_reset = (state_q == TLR);
  assign bus.capture_dr       = (state_q == CAPDR);
  assign bus.shift_dr         = (state_q == SHDR);
  assign bus.update_dr        = (state_q == UPDDR);
  assign bus.capture_ir       = (state_q == CAPIR);
  assign bus.shift_ir         = (state_q == SHIR);
  assign bus.update_ir        = (state_q == UPDIR);

endmodule

// File: rtl/tap_ctrl_param.sv
// Parametrised TAP controller: instruction register, bypass, IDCODE and one
// user data register with parallel capture/update, plus the TDO mux.
module tap_ctrl_param
  import tap_pkg::*;
#(
  parameter int              IR_W       = 4,
  parameter int              DR_W       = 8,
  parameter logic [31:0]     IDCODE_VAL = 32'h0000_0001,
  parameter logic [IR_W-1:0] IDCODE_OP  = IR_W'(1),
  parameter logic [IR_W-1:0] USER_OP    = IR_W'(2)
) (
  input  logic            GCLK_Pad,
  input  logic            TRST_N_Pad,
  input  logic            TMS_Pad,
  input  logic            TDI_Pad,
  output logic            TDO_Pad,
  output logic            tdo_en_Pad,
  output logic [3:0]      state_obs_Pad,
  output logic [IR_W-1:0] ir_Pad,
  input  logic [DR_W-1:0] user_dr_in,
  output logic [DR_W-1:0] user_dr_out,
  output logic            user_upd
);

  tap_ctrl_param_if fsm_if ();

  assign fsm_if.tms = TMS_Pad;

  tap_fsm u_fsm (
    .clk   (GCLK_Pad),
    .rst_n (TRST_N_Pad),
    .bus   (fsm_if)
  );

  logic [IR_W-1:0] ir_q, ir_d;
  logic [IR_W-1:0] ir_sr_q, ir_sr_d;
  logic [31:0]     idcode_sr_q, idcode_sr_d;
  logic [DR_W-1:0] user_sr_q, user_sr_d;
  logic            bypass_q, bypass_d;
  logic [DR_W-1:0] user_dr_out_q, user_dr_out_d;
  logic            user_upd_q, user_upd_d;
  logic [DR_W:0]   user_cat;
  dr_sel_e         dr_sel;
  logic            tdo;

  // Any code that is neither IDCODE nor USER, including all-ones, is bypass.
  always_comb begin
    if (ir_q == IDCODE_OP) begin
      dr_sel = SEL_IDCODE;
    end else if (ir_q == USER_OP) begin
      dr_sel = SEL_USER;
    end else begin
      dr_sel = SEL_BYPASS;
    end
  end

  assign user_cat = {TDI_Pad, user_sr_q};

  always_comb begin
    ir_d          = ir_q;
    ir_sr_d       = ir_sr_q;
    idcode_sr_d   = idcode_sr_q;
    user_sr_d     = user_sr_q;
    bypass_d      = bypass_q;
    user_dr_out_d = user_dr_out_q;
    user_upd_d    = 1'b0;

    if (fsm_if.test_logic_reset) begin
      ir_d = IDCODE_OP;
    end
    if (fsm_if.capture_ir) begin
      ir_sr_d = IR_W'(IR_CAPTURE);
    end
    if (fsm_if.shift_ir) begin
      ir_sr_d = {TDI_Pad, ir_sr_q[IR_W-1:1]};
    end
    if (fsm_if.update_ir) begin
      ir_d = ir_sr_q;
    end

    if (fsm_if.capture_dr) begin
      case (dr_sel)
        SEL_IDCODE: idcode_sr_d = IDCODE_VAL;
        SEL_USER:   user_sr_d   = user_dr_in;
        default:    bypass_d    = 1'b0;
      endcase
    end
    if (fsm_if.shift_dr) begin
      case (dr_sel)
        SEL_IDCODE: idcode_sr_d = {TDI_Pad, idcode_sr_q[31:1]};
        SEL_USER:   user_sr_d   = user_cat[DR_W:1];
        default:    bypass_d    = TDI_Pad;
      endcase
    end
    if (fsm_if.update_dr && (dr_sel == SEL_USER)) begin
      user_dr_out_d = user_sr_q;
      user_upd_d    = 1'b1;
    end
  end

  always_ff @(posedge GCLK_Pad or negedge TRST_N_Pad) begin
    if (!TRST_N_Pad) begin
      ir_q          <= IDCODE_OP;
      ir_sr_q       <= '0;
      idcode_sr_q   <= '0;
      user_sr_q     <= '0;
      bypass_q      <= 1'b0;
      user_dr_out_q <= '0;
      user_upd_q    <= 1'b0;
    end else begin
      ir_q          <= ir_d;
      ir_sr_q       <= ir_sr_d;
      idcode_sr_q   <= idcode_sr_d;
      user_sr_q     <= user_sr_d;
      bypass_q      <= bypass_d;
      user_dr_out_q <= user_dr_out_d;
      user_upd_q    <= user_upd_d;
    end
  end

  // TDO is the LSB of whichever register is shifting, so the first captured
  // bit is already visible during the first shift cycle.
  always_comb begin
    tdo = 1'b0;
    if (fsm_if.shift_ir) begin
      tdo = ir_sr_q[0];
    end else if (fsm_if.shift_dr) begin
      case (dr_sel)
        SEL_IDCODE: tdo = idcode_sr_q[0];
        SEL_USER:   tdo = user_sr_q[0];
        default:    tdo = bypass_q;
      endcase
    end
  end

  assign TDO_Pad       = tdo;
  assign tdo_en_Pad    = fsm_if.shift_ir | fsm_if.shift_dr;
  assign state_obs_Pad = fsm_if.state;
  assign ir_Pad        = ir_q;
  assign user_dr_out   = user_dr_out_q;
  assign user_upd      = user_upd_q;

endmodule
